// File: rtl/kamus_pkg.sv
// Shared types for the kamus core: L1D access sizes and L1D clear/ready states.
package kamus_pkg;

    typedef enum logic [1:0] {
        L1D_BYTE = 2'b00,
        L1D_HALF = 2'b01,
        L1D_WORD = 2'b10
    } l1d_size_e;

    typedef enum logic {
        L1D_CLEAR = 1'b0,
        L1D_READY = 1'b1
    } l1d_state_e;

endpackage

// File: rtl/kamus_l1d_lane.sv
// Byte-lane steering for the L1D: write strobes, shifted store data,
// right-aligned load extraction and the misaligned flag.
module kamus_l1d_lane
    import kamus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  strb,
    output logic [31:0] wr_data_sh,
    output logic [31:0] rd_data,
    output logic        misaligned
);

    logic [4:0]  bit_sh;
    logic [31:0] rd_sh;

    assign bit_sh     = {offset, 3'b000};
    assign rd_sh      = rd_word >> bit_sh;
    assign wr_data_sh = wr_data << bit_sh;

    // Size 2'b11 falls into the default arm and behaves as a word access.
    always_comb begin
        strb       = 4'b0000;
        rd_data    = 32'h0;
        misaligned = 1'b0;
        case (size)
            L1D_BYTE: begin
                strb    = 4'b0001 << offset;
                rd_data = {24'h0, rd_sh[7:0]};
            end
            L1D_HALF: begin
                strb       = 4'b0011 << offset;
                rd_data    = {16'h0, rd_sh[15:0]};
                misaligned = offset[0];
            end
            default: begin
                strb       = 4'b1111 << offset;
                rd_data    = rd_sh;
                misaligned = |offset;
            end
        endcase
    end

endmodule

// File: rtl/kamus_l1d.sv
// L1 data scratchpad: combinational read, byte-lane synchronous write,
// zeroed by a clear sweep after reset; illegal writes are dropped and flagged.
module kamus_l1d
    import kamus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        l1d_wr_en_i,
    input  logic [31:0] l1d_addr_i,
    input  logic [31:0] l1d_wr_data_i,
    input  logic [1:0]  l1d_size_i,
    output logic [31:0] l1d_rd_data_o,
    output logic        l1d_ready_o,
    output logic        l1d_misaligned_o,
    output logic        l1d_oor_o,
    output logic        l1d_err_o
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem [DEPTH_WORDS];

    l1d_state_e       state;
    logic [IDX_W-1:0] clr_idx;
    logic             ready_q;
    logic             err_q;

    logic [31:0]      off;
    logic             oor;
    logic             misaligned;
    logic             legal;
    logic [IDX_W-1:0] idx;
    logic [3:0]       strb;
    logic [31:0]      wr_data_sh;
    logic [31:0]      lane_rd;

    // Subtraction wraps for addresses below BASE_ADDR, so that case is tested separately.
    assign off   = l1d_addr_i - BASE_ADDR;
    assign oor   = (l1d_addr_i < BASE_ADDR) || ({1'b0, off} >= SPAN);
    assign idx   = off[IDX_W+1:2];
    assign legal = !oor && !misaligned;

    kamus_l1d_lane u_lane (
        .size       (l1d_size_i),
        .offset     (l1d_addr_i[1:0]),
        .wr_data    (l1d_wr_data_i),
        .rd_word    (mem[idx]),
        .strb       (strb),
        .wr_data_sh (wr_data_sh),
        .rd_data    (lane_rd),
        .misaligned (misaligned)
    );

    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_word;

    // The clear sweep owns the write port; MEM-stage stores are ignored until ready.
    always_comb begin
        wr_idx  = idx;
        wr_be   = 4'b0000;
        wr_word = wr_data_sh;
        if (rst_ni) begin
            if (state == L1D_CLEAR) begin
                wr_idx  = clr_idx;
                wr_be   = 4'b1111;
                wr_word = 32'h0;
            end else if (l1d_wr_en_i && legal) begin
                wr_be = strb;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= L1D_CLEAR;
            clr_idx <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                L1D_CLEAR: begin
                    if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                        state   <= L1D_READY;
                        ready_q <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + IDX_W'(1);
                    end
                end
                default: begin
                    if (l1d_wr_en_i && !legal) err_q <= 1'b1;
                end
            endcase
        end
    end

    assign l1d_rd_data_o    = (ready_q && legal) ? lane_rd : 32'h0;
    assign l1d_ready_o      = ready_q;
    assign l1d_misaligned_o = misaligned;
    assign l1d_oor_o        = oor;
    assign l1d_err_o        = err_q;

endmodule

// File: tb/tb_kamus_l1d.sv
// Self-checking bench for kamus_l1d against a byte-addressed reference memory.
module tb_kamus_l1d;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam int          SPAN_B = 4 * DEPTH;

    logic        clk;
    logic        rst_ni;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [1:0]  size;
    logic [31:0] rd_data;
    logic        ready;
    logic        misaligned;
    logic        oor;
    logic        err;

    kamus_l1d #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .l1d_wr_en_i      (wr_en),
        .l1d_addr_i       (addr),
        .l1d_wr_data_i    (wr_data),
        .l1d_size_i       (size),
        .l1d_rd_data_o    (rd_data),
        .l1d_ready_o      (ready),
        .l1d_misaligned_o (misaligned),
        .l1d_oor_o        (oor),
        .l1d_err_o        (err)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: flat byte memory
    logic [7:0]  m_mem [SPAN_B];
    bit          m_err;
    bit          m_ready;
    logic [31:0] exp_q [$];
    int          n_cmp;
    int          n_mis;

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_oor(input logic [31:0] a);
        return (a < BASE) || (a >= BASE + SPAN_B);
    endfunction

    function automatic bit m_misal(input logic [31:0] a, input logic [1:0] s);
        return (a % nbytes(s)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] v;
        v = 32'h0;
        if (!m_ready || m_oor(a) || m_misal(a, s)) return v;
        for (int i = 0; i < nbytes(s); i++) v[8*i +: 8] = m_mem[int'(a - BASE) + i];
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        if (!m_ready) return;
        if (m_oor(a) || m_misal(a, s)) begin
            m_err = 1'b1;
            return;
        end
        for (int i = 0; i < nbytes(s); i++) m_mem[int'(a - BASE) + i] = d[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // driver tasks
    task automatic access(input logic we, input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] d, input string tag);
        @(negedge clk);
        wr_en = we; addr = a; size = s; wr_data = d;
        #1;
        exp_q.push_back(m_load(a, s));
        check({tag, "_rd"}, rd_data, exp_q.pop_front());
        check({tag, "_mis"}, 32'(misaligned), 32'(m_misal(a, s)));
        check({tag, "_oor"}, 32'(oor), 32'(m_oor(a)));
        if (we) m_store(a, s, d);
        @(posedge clk);
        #1;
        check({tag, "_err"}, 32'(err), 32'(m_err));
    endtask

    task automatic load_const(input logic [31:0] a, input logic [1:0] s,
                              input logic [31:0] exp, input string tag);
        @(negedge clk);
        wr_en = 1'b0; addr = a; size = s;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic run_reset(input int abort_after);
        @(posedge clk);
        #1;
        rst_ni = 1'b0; wr_en = 1'b0; addr = BASE; size = 2'd2;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rd", rd_data, 32'h0);
        rst_ni = 1'b1;
        if (abort_after > 0) begin
            repeat (abort_after) @(posedge clk);
            #1;
            check("abort_ready", 32'(ready), 32'h0);
            rst_ni = 1'b0;
            @(posedge clk);
            #1;
            rst_ni = 1'b1;
        end
        m_ready = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            wr_en = 1'b1; size = 2'd2; wr_data = $urandom;
            addr = (k % 2 == 1) ? BASE + 32'h4 : BASE + 32'h6;
            #1;
            check("clr_rd", rd_data, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("ready_cnt%0d", k), 32'(ready), 32'(k == DEPTH));
        end
        for (int i = 0; i < SPAN_B; i++) m_mem[i] = 8'h00;
        m_err   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("clr_err", 32'(err), 32'h0);
        load_const(BASE + 32'h4, 2'd2, 32'h0, "clr_store_ignored");
    endtask

    // main sequence
    initial begin
        n_cmp = 0; n_mis = 0;
        rst_ni = 1'b0; wr_en = 1'b0; addr = BASE; wr_data = 32'h0; size = 2'd2;
        m_err = 1'b0; m_ready = 1'b0;

        run_reset(0);
        for (int w = 0; w < DEPTH; w++) load_const(BASE + 32'(4 * w), 2'd2, 32'h0, "zero_word");

        run_reset(8);

        access(1'b1, BASE + 32'h8, 2'd2, 32'hDEADBEEF, "sw8");
        load_const(BASE + 32'h8, 2'd2, 32'hDEADBEEF, "lw8");

        access(1'b1, BASE + 32'h10, 2'd2, 32'h11223344, "preload");
        access(1'b1, BASE + 32'h12, 2'd0, 32'h000000AA, "sb12");
        load_const(BASE + 32'h10, 2'd2, 32'h11AA3344, "after_sb");
        load_const(BASE + 32'h12, 2'd0, 32'h000000AA, "lb12");
        access(1'b1, BASE + 32'h10, 2'd1, 32'h00005566, "sh10");
        load_const(BASE + 32'h10, 2'd2, 32'h11AA5566, "after_sh");
        load_const(BASE + 32'h12, 2'd1, 32'h000011AA, "lh12");

        access(1'b1, BASE + 32'h6, 2'd2, 32'hCAFEF00D, "sw_mis");
        load_const(BASE + 32'h4, 2'd2, 32'h0, "mis_unchanged");
        check("mis_err", 32'(err), 32'h1);
        access(1'b0, BASE + 32'h3, 2'd1, 32'h0, "lh_mis");
        load_const(BASE + 32'h3, 2'd1, 32'h0, "lh_mis_zero");

        run_reset(0);
        access(1'b1, BASE, 2'd2, 32'h0BADF00D, "sw_base");
        access(1'b1, BASE + SPAN_B, 2'd2, 32'h12345678, "sw_oor");
        load_const(BASE, 2'd2, 32'h0BADF00D, "oor_unchanged");
        check("oor_err", 32'(err), 32'h1);
        access(1'b0, BASE - 32'h4, 2'd2, 32'h0, "lw_below");
        run_reset(0);

        for (int batch = 0; batch < 2; batch++) begin
            for (int n = 0; n < 300; n++) begin
                logic [31:0] ra;
                ra = BASE - 32'd8 + 32'($urandom_range(0, SPAN_B + 15));
                access(1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)), $urandom, "rnd");
            end
            run_reset(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
